// File: rtl/pair_proc_mem.sv
// Pair processor: loads 2**ADDR_A words into memory A, then writes one result per
// word pair into memory B (sum when first <= second, else difference). Optional macro
// PAIR_PROC_SAT_EN makes the add path saturate instead of wrapping.
module pair_proc_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_A = 3
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Init,
  input  logic              Start,
  input  logic [WIDTH-1:0]  DataInA,
  input  logic              DataValid,
  input  logic [ADDR_A-2:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_A-1:0] NumAdds,
  output logic [1:0]        state_dbg
);

  localparam int DEPTH   = 2 ** ADDR_A;
  localparam int DEPTH_B = DEPTH / 2;

  localparam logic [ADDR_A-1:0] A_LAST    = ADDR_A'(DEPTH - 1);
  localparam logic [ADDR_A:0]   COMP_LAST = (ADDR_A + 1)'(DEPTH);
  localparam logic [ADDR_A-1:0] A_ONE     = ADDR_A'(1);
  localparam logic [ADDR_A-2:0] B_ONE     = (ADDR_A - 1)'(1);
  localparam logic [ADDR_A:0]   C_ONE     = (ADDR_A + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_COMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_A-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_A-2:0]   addr_b_q, addr_b_d;
  logic [ADDR_A-1:0]   num_adds_q, num_adds_d;
  logic [WIDTH-1:0]    hold_q, hold_d;
  logic [ADDR_A:0]     comp_cnt_q, comp_cnt_d;
  logic [WIDTH-1:0]    rd_data_b_q;

  logic [WIDTH-1:0]    mem_a_q [DEPTH];
  logic [WIDTH-1:0]    mem_b_q [DEPTH_B];
  logic [WIDTH-1:0]    dout_a_q;

  logic                a_we;
  logic                b_we;
  logic [ADDR_A-1:0]   a_raddr;
  logic                a_le_b;
  logic [WIDTH:0]      sum_ext;
  logic [WIDTH-1:0]    add_res;
  logic [WIDTH-1:0]    diff_res;
  logic [WIDTH-1:0]    pair_res;

  // Pair datapath: a is the held even word, b is the odd word arriving from memory A.
  always_comb begin
    a_le_b   = (hold_q <= dout_a_q);
    sum_ext  = {1'b0, hold_q} + {1'b0, dout_a_q};
`ifdef PAIR_PROC_SAT_EN
    add_res  = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
    add_res  = sum_ext[WIDTH-1:0];
`endif
    diff_res = hold_q - dout_a_q;
    pair_res = a_le_b ? add_res : diff_res;
  end

  assign a_raddr = comp_cnt_q[ADDR_A-1:0];

  // DataInA has no back-pressure: in LOAD every cycle with DataValid=1 is one accepted
  // word; DataValid is ignored in every other state.
  always_comb begin
    state_d    = state_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    num_adds_d = num_adds_q;
    hold_d     = hold_q;
    comp_cnt_d = comp_cnt_q;
    a_we       = 1'b0;
    b_we       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d    = S_LOAD;
          addr_a_d   = '0;
          addr_b_d   = '0;
          num_adds_d = '0;
          comp_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (DataValid) begin
          a_we     = 1'b1;
          addr_a_d = addr_a_q + A_ONE;
          if (addr_a_q == A_LAST) begin
            state_d    = S_COMP;
            comp_cnt_d = '0;
          end
        end
      end
      S_COMP: begin
        // Cycle c reads word c; word c-1 is on dout_a_q. Odd c holds an even word,
        // even c > 0 completes a pair.
        comp_cnt_d = comp_cnt_q + C_ONE;
        if (comp_cnt_q != '0) begin
          if (comp_cnt_q[0]) begin
            hold_d = dout_a_q;
          end else begin
            b_we     = 1'b1;
            addr_b_d = addr_b_q + B_ONE;
            if (a_le_b) begin
              num_adds_d = num_adds_q + A_ONE;
            end
          end
        end
        if (comp_cnt_q == COMP_LAST) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (Init) begin
      state_d    = S_IDLE;
      addr_a_d   = '0;
      addr_b_d   = '0;
      num_adds_d = '0;
      hold_d     = '0;
      comp_cnt_d = '0;
      a_we       = 1'b0;
      b_we       = 1'b0;
    end

    if (Reset) begin
      a_we = 1'b0;
      b_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      num_adds_q <= '0;
      hold_q     <= '0;
      comp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      num_adds_q <= num_adds_d;
      hold_q     <= hold_d;
      comp_cnt_q <= comp_cnt_d;
    end
  end

  // Memory contents survive Reset and Init; only the write enables are suppressed.
  always_ff @(posedge clock) begin
    if (a_we) begin
      mem_a_q[addr_a_q] <= DataInA;
    end
    dout_a_q <= mem_a_q[a_raddr];
  end

  always_ff @(posedge clock) begin
    if (b_we) begin
      mem_b_q[addr_b_q] <= pair_res;
    end
  end

  // Readback port is independent of the write port; a same-address collision reads old data.
  always_ff @(posedge clock) begin
    if (Reset) begin
      rd_data_b_q <= '0;
    end else begin
      rd_data_b_q <= mem_b_q[RdAddrB];
    end
  end

  assign RdDataB   = rd_data_b_q;
  assign Busy      = (state_q == S_LOAD) || (state_q == S_COMP);
  assign Done      = (state_q == S_DONE);
  assign NumAdds   = num_adds_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pair_proc_mem.sv
// Self-checking bench for pair_proc_mem (WIDTH=8, ADDR_A=3) against a pair-rule model.
module tb_pair_proc_mem;

  localparam int WIDTH  = 8;
  localparam int ADDR_A = 3;
  localparam int DEPTH  = 8;
  localparam int NPAIR  = 4;

  logic              clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Init = 1'b0;
  logic              Start = 1'b0;
  logic [WIDTH-1:0]  DataInA = '0;
  logic              DataValid = 1'b0;
  logic [ADDR_A-2:0] RdAddrB = '0;
  logic [WIDTH-1:0]  RdDataB;
  logic              Busy;
  logic              Done;
  logic [ADDR_A-1:0] NumAdds;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  int busy_total = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_adds;
  logic [WIDTH-1:0] words [DEPTH];

  pair_proc_mem #(.WIDTH(WIDTH), .ADDR_A(ADDR_A)) dut (
    .clock(clock), .Reset(Reset), .Init(Init), .Start(Start),
    .DataInA(DataInA), .DataValid(DataValid), .RdAddrB(RdAddrB),
    .RdDataB(RdDataB), .Busy(Busy), .Done(Done), .NumAdds(NumAdds),
    .state_dbg(state_dbg)
  );

  // Clock and busy-cycle monitor
  always #5 clock = ~clock;
  always @(posedge clock) if (Busy) busy_total++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: one result per pair from the arithmetic rule.
  task automatic model();
    exp_q.delete();
    exp_adds = 0;
    for (int k = 0; k < NPAIR; k++) begin
      int a;
      int b;
      int s;
      a = int'(words[2*k]);
      b = int'(words[2*k+1]);
      if (a <= b) begin
        s = a + b;
`ifdef PAIR_PROC_SAT_EN
        if (s > 255) s = 255;
`else
        s = s % 256;
`endif
        exp_adds++;
      end else begin
        s = a - b;
      end
      exp_q.push_back(s[WIDTH-1:0]);
    end
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // stall_mode: 0 none, 1 alternate cycles, 2 random gaps
  task automatic load(input int stall_mode, input int n, output int cyc);
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = 0;
      if (i > 0 && stall_mode == 1) gaps = 1;
      if (i > 0 && stall_mode == 2) gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        DataValid = 1'b0;
        DataInA = WIDTH'($urandom);
        tick();
        cyc++;
      end
      DataValid = 1'b1;
      DataInA = words[i];
      tick();
      cyc++;
    end
    DataValid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_busy, input int busy0, input bit noise);
    int n;
    n = 0;
    while (!Done && n < 200) begin
      if (noise) begin
        DataValid = 1'($urandom_range(0, 1));
        DataInA = WIDTH'($urandom);
      end
      tick();
      n++;
    end
    DataValid = 1'b0;
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: got Done=%b expected 1 within 200 cycles", name, Done);
    end else begin
      checks++;
      if (busy_total - busy0 !== exp_busy) begin
        errors++;
        $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_total - busy0, exp_busy);
      end
    end
  endtask

  task automatic check_b(input string name);
    for (int n = 0; n < NPAIR; n++) begin
      RdAddrB = (ADDR_A-1)'(n);
      tick();
      checks++;
      if (RdDataB !== exp_q[n]) begin
        errors++;
        $display("FAIL %s_b%0d: got %0d expected %0d", name, n, RdDataB, exp_q[n]);
      end
    end
    checks++;
    if (NumAdds !== ADDR_A'(exp_adds)) begin
      errors++;
      $display("FAIL %s_numadds: got %0d expected %0d", name, NumAdds, exp_adds);
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_hold: got %b expected 1", name, Done);
    end
  endtask

  task automatic full_run(input string name, input int stall_mode, input bit noise);
    int b0;
    int cyc;
    b0 = busy_total;
    do_start();
    load(stall_mode, DEPTH, cyc);
    wait_done(name, cyc + DEPTH + 1, b0, noise);
    check_b(name);
  endtask

  task automatic check_idle(input string name, input bit rd_zero);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || NumAdds !== '0) begin
      errors++;
      $display("FAIL %s_idle: got Busy=%b Done=%b NumAdds=%0d expected 0 0 0", name, Busy, Done, NumAdds);
    end
    if (rd_zero) begin
      checks++;
      if (RdDataB !== '0) begin
        errors++;
        $display("FAIL %s_rddata: got %0d expected 0", name, RdDataB);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    check_idle("reset", 1'b1);
    Reset = 1'b0;
    tick();
    check_idle("after_reset", 1'b0);
  endtask

  task automatic test_nominal();
    words = '{8'd10, 8'd20, 8'd50, 8'd30, 8'd7, 8'd7, 8'd200, 8'd100};
    exp_q = '{8'd30, 8'd20, 8'd14, 8'd100};
    exp_adds = 2;
    full_run("nominal", 0, 1'b0);
  endtask

  task automatic test_overflow();
    words = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd0, 8'd0, 8'd1, 8'd2};
`ifdef PAIR_PROC_SAT_EN
    exp_q = '{8'd255, 8'd255, 8'd0, 8'd3};
`else
    exp_q = '{8'd44, 8'd254, 8'd0, 8'd3};
`endif
    exp_adds = 4;
    full_run("overflow", 0, 1'b0);
  endtask

  task automatic test_stalled();
    words = '{8'd10, 8'd20, 8'd50, 8'd30, 8'd7, 8'd7, 8'd200, 8'd100};
    model();
    DataValid = 1'b1;
    DataInA = 8'hEE;
    tick();
    DataValid = 1'b0;
    full_run("stalled", 1, 1'b1);
  endtask

  task automatic test_init_abort();
    int cyc;
    words = '{8'd10, 8'd20, 8'd50, 8'd30, 8'd7, 8'd7, 8'd200, 8'd100};
    do_start();
    load(0, DEPTH, cyc);
    tick();
    tick();
    tick();
    Init = 1'b1;
    tick();
    Init = 1'b0;
    check_idle("init", 1'b0);
    tick();
    tick();
    check_idle("init_stay", 1'b0);
    words = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd0, 8'd0, 8'd1, 8'd2};
    model();
    full_run("after_init", 0, 1'b0);
  endtask

  task automatic test_reset_midload();
    int cyc;
    for (int i = 0; i < DEPTH; i++) words[i] = WIDTH'($urandom);
    do_start();
    load(0, 4, cyc);
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    check_idle("reset_mid", 1'b1);
    tick();
    check_idle("reset_start_ignored", 1'b1);
    Reset = 1'b0;
    Start = 1'b0;
    tick();
    check_idle("reset_release", 1'b0);
    model();
    full_run("after_reset", 2, 1'b0);
  endtask

  task automatic test_readback();
    RdAddrB = '0;
    tick();
    for (int n = 1; n < NPAIR; n++) begin
      RdAddrB = (ADDR_A-1)'(n);
      #2;
      checks++;
      if (RdDataB !== exp_q[n-1]) begin
        errors++;
        $display("FAIL readback_latency%0d: got %0d expected %0d", n, RdDataB, exp_q[n-1]);
      end
      tick();
      checks++;
      if (RdDataB !== exp_q[n]) begin
        errors++;
        $display("FAIL readback_b%0d: got %0d expected %0d", n, RdDataB, exp_q[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    int cyc;
    for (int i = 0; i < DEPTH; i++) words[i] = WIDTH'($urandom_range(0, 255));
    model();
    b0 = busy_total;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL relaunch: got Done=%b Busy=%b expected 0 1", Done, Busy);
    end
    load(0, DEPTH, cyc);
    wait_done("back_to_back", cyc + DEPTH + 1, b0, 1'b0);
    check_b("back_to_back");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        case ($urandom_range(0, 3))
          0: words[i] = WIDTH'($urandom_range(240, 255));
          1: words[i] = (i % 2 == 1) ? words[i-1] : WIDTH'($urandom_range(0, 15));
          default: words[i] = WIDTH'($urandom_range(0, 255));
        endcase
      end
      model();
      full_run("random", 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow();
    test_stalled();
    test_init_abort();
    test_reset_midload();
    test_readback();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
